// File: rtl/bf_uart_tx.sv
// bf_uart_tx: buffered UART transmitter draining a byte FIFO onto a serial line
// Ports: clk (board clock), rst (async active-high reset), wr_en/wr_data (byte write strobe),
//        uart_tx (serial line, idles high), full/empty/level (FIFO status),
//        busy (frame in progress), overflow (sticky dropped-write flag).
// Define BF_UART_TX_PARITY_EN for 8E1 frames; 8N1 otherwise.
module bf_uart_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          uart_tx,
    output logic                          full,
    output logic                          empty,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef BF_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;
`ifdef BF_UART_TX_PARITY_EN
    logic          par_q;
`endif
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, level_q, level_d;
    logic          full_q, empty_q, ovf_q;
    logic          push, pop, bit_end;
    logic [7:0]    head;
    assign head = mem_q[rd_ptr_q[AW-1:0]];
    always_comb begin
        push     = wr_en && !full_q;
        bit_end  = cnt_q == LAST;
        // The FSM takes the head byte when idle, or at the last STOP cycle for gapless frames.
        pop      = !empty_q && (state_q == IDLE || (state_q == STOP && bit_end));
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = wr_ptr_d - rd_ptr_d;
    end
    always_ff @(posedge clk)
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= level_d == PW'(FIFO_DEPTH);
            empty_q  <= wr_ptr_d == rd_ptr_d;
            // full_q is the pre-pop view, so a write racing a pop is still dropped.
            if (wr_en && full_q) ovf_q <= 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef BF_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= START;
                        shift_q <= head;
`ifdef BF_UART_TX_PARITY_EN
                        par_q   <= ^head;
`endif
                        cnt_q   <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
                    if (bit_end) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
`ifdef BF_UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
`ifdef BF_UART_TX_PARITY_EN
                PARITY: begin
                    cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
                    if (bit_end) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
                    if (bit_end) begin
                        if (pop) begin
                            state_q <= START;
                            shift_q <= head;
`ifdef BF_UART_TX_PARITY_EN
                            par_q   <= ^head;
`endif
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign uart_tx  = tx_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = ovf_q;
    assign level    = level_q;
endmodule

// File: tb/tb_bf_uart_tx.sv
// tb_bf_uart_tx: self-checking bench for bf_uart_tx with a line-decoding scoreboard
module tb_bf_uart_tx;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 75_000;
    localparam int DEPTH  = 16;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef BF_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       uart_tx, full, empty, busy, overflow;
    logic [4:0] level;

    bf_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .uart_tx(uart_tx), .full(full), .empty(empty), .busy(busy),
        .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb[$];
    bit         mon_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
    endtask

    task automatic idle();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(busy === 1'b0 && empty === 1'b1) && n < 20 * FRAME) begin
            step();
            n++;
        end
        chk("drain_busy", busy, 0);
        chk("drain_sb", sb.size(), 0);
    endtask

    // Line decoder: samples mid-bit and pops the scoreboard per frame.
    initial begin : mon
        logic [7:0] d;
        forever begin
            step();
            if (mon_en && !rst && uart_tx === 1'b0) begin
                repeat (DIV / 2) step();
                chk("mon_start", uart_tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) step();
                    d[i] = uart_tx;
                end
`ifdef BF_UART_TX_PARITY_EN
                repeat (DIV) step();
                chk("mon_parity", uart_tx, ^d);
`endif
                repeat (DIV) step();
                chk("mon_stop", uart_tx, 1);
                chk("mon_expected_frame", sb.size() > 0, 1);
                if (sb.size() > 0) chk("mon_byte", d, sb.pop_front());
                repeat (DIV - DIV / 2 - 1) step();
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] d;
        logic       p;
    } vec_t;
    vec_t tv[6];

    initial begin : main
        int         n, s, c1, c2, bad;
        logic [10:0] got, exp;
        tv[0] = '{8'h41, 1'b0};
        tv[1] = '{8'h00, 1'b0};
        tv[2] = '{8'hFF, 1'b0};
        tv[3] = '{8'h80, 1'b1};
        tv[4] = '{8'h07, 1'b1};
        tv[5] = '{8'h5A, 1'b0};

        @(negedge clk);
        chk("rst_tx", uart_tx, 1);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_level", level, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            sb.push_back(tv[v].d);
            put(tv[v].d);
            step();
            chk("wr_level", level, 1);
            chk("wr_empty", empty, 0);
            chk("wr_tx_idle", uart_tx, 1);
            idle();
            step();
            chk("start_tx", uart_tx, 0);
            chk("start_busy", busy, 1);
            n = 0;
            got = '1;
            while (busy === 1'b1 && n < FRAME + 20) begin
                if (n < FRAME && n % DIV == DIV / 2) got[n / DIV] = uart_tx;
                n++;
                step();
            end
            chk("busy_cycles", n, FRAME);
            exp = '1;
            exp[0] = 1'b0;
            exp[8:1] = tv[v].d;
`ifdef BF_UART_TX_PARITY_EN
            exp[9] = tv[v].p;
`endif
            chk("frame_bits", got, exp);
            chk("after_level", level, 0);
        end

        // Back-to-back: two bytes queued behind a frame already on the line.
        sb.push_back(8'h33);
        sb.push_back(8'h55);
        sb.push_back(8'hAA);
        put(8'h33);
        idle();
        step();
        chk("b2b_busy", busy, 1);
        put(8'h55);
        put(8'hAA);
        idle();
        step();
        chk("b2b_level2", level, 2);
        n = 0;
        while (level === 5'd2 && n < FRAME + 20) begin step(); n++; end
        c1 = cyc;
        chk("b2b_level1", level, 1);
        chk("b2b_nogap1", uart_tx, 0);
        n = 0;
        while (level === 5'd1 && n < FRAME + 20) begin step(); n++; end
        c2 = cyc;
        chk("b2b_level0", level, 0);
        chk("b2b_nogap2", uart_tx, 0);
        chk("b2b_spacing", c2 - c1, FRAME);
        n = 0;
        while (busy === 1'b1 && n < FRAME + 20) begin step(); n++; end
        chk("b2b_tail", n, FRAME);
        wait_drain();

        // Overflow: 17 writes while the line is busy; the 17th is dropped.
        sb.push_back(8'hC3);
        put(8'hC3);
        idle();
        step();
        for (int i = 0; i < 17; i++) begin
            put(8'(i));
            if (i < 16) sb.push_back(8'(i));
            step();
            if (i == 15) begin
                chk("ovf16_full", full, 1);
                chk("ovf16_flag", overflow, 0);
                chk("ovf16_level", level, 16);
            end
        end
        chk("ovf17_full", full, 1);
        chk("ovf17_flag", overflow, 1);
        chk("ovf17_level", level, 16);
        idle();
        wait_drain();
        chk("ovf_sticky", overflow, 1);

        // Full FIFO with a write on the same edge as the STOP-end pop.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("clr_ovf", overflow, 0);
        sb.push_back(8'h5A);
        put(8'h5A);
        idle();
        step();
        s = cyc;
        chk("fwp_busy", busy, 1);
        for (int i = 0; i < 16; i++) begin
            put(8'h80 + 8'(i));
            sb.push_back(8'h80 + 8'(i));
            step();
        end
        idle();
        while (cyc < s + FRAME - 1) @(negedge clk);
        chk("fwp_full_before", full, 1);
        chk("fwp_level_before", level, 16);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        step();
        chk("fwp_ovf", overflow, 1);
        chk("fwp_level", level, 15);
        chk("fwp_full", full, 0);
        chk("fwp_next_start", uart_tx, 0);
        idle();
        wait_drain();

        // Reset during DATA bit 3 with another byte still queued.
        mon_en = 1'b0;
        put(8'h07);
        put(8'hF0);
        idle();
        step();
        repeat (4 * DIV + DIV / 2 - 1) step();
        chk("mid_level", level, 1);
        chk("mid_bit3", uart_tx, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx", uart_tx, 1);
        chk("arst_busy", busy, 0);
        chk("arst_level", level, 0);
        chk("arst_empty", empty, 1);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (12 * DIV) begin
            step();
            if (uart_tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) bad++;
        end
        chk("no_residual", bad, 0);
        mon_en = 1'b1;

        chk("final_sb", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bf_uart_tx.md
# bf_uart_tx

Buffered 8N1 UART transmitter that consumes the output bytes produced by the Brainfuck core's `.` instruction. It sits directly downstream of the SFR output register, and is clocked by the fast board clock rather than the divided core clock. Writes are queued in a small FIFO so core execution never waits on the serial line. The FIFO drains onto `uart_tx` at a fixed baud rate.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000 — frequency of `clk` in Hz.
- `BAUD`, default 115200 — line rate.
- `FIFO_DEPTH`, default 16 — byte slots; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  — board clock; the only clock.
- `rst`  in  1  — reset, asynchronous, active-high.
- `wr_en`  in  1  — single-cycle write strobe, synchronous to `clk`.
- `wr_data`  in  8  — byte to send; sampled when `wr_en` = 1.
- `uart_tx`  out  1  — serial line; idles high.
- `full`  out  1  — FIFO holds `FIFO_DEPTH` bytes.
- `empty`  out  1  — FIFO holds 0 bytes.
- `busy`  out  1  — FSM not in IDLE.
- `overflow`  out  1  — sticky: a write was dropped; cleared only by `rst`.
- `level`  out  $clog2(FIFO_DEPTH)+1  — current FIFO occupancy.

## Operation
- Baud divisor: `DIV = CLK_HZ / BAUD`, truncated integer. Bit counter runs 0..DIV-1, and each line bit lasts exactly DIV `clk` cycles.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address.
  - `full` = (level == FIFO_DEPTH) and `empty` = (level == 0), both registered from the pointers.
- Write rule:
  - `wr_en` with `full`=0 stores the byte and increments `level`.
  - `wr_en` with `full`=1 drops the byte and sets `overflow`. This holds even if a pop occurs on the same edge, because `full` is evaluated before the pop.
- Simultaneous write and pop with `full`=0: both happen and `level` is unchanged.
- FSM states: IDLE → START → DATA → (PARITY) → STOP.
  - IDLE: `uart_tx`=1. If `empty`=0, pop the head byte into the shift register, clear the bit counter, go to START.
  - START: `uart_tx`=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: `uart_tx`=shift[0], LSB first. After each DIV cycles, shift right and increment the index. After index 7 completes, go to PARITY if the macro is enabled, else STOP.
  - PARITY: `uart_tx` = XOR of the 8 data bits (even parity) for DIV cycles, then go to STOP.
  - STOP: `uart_tx`=1 for DIV cycles. At the last cycle, if `empty`=0, pop and go straight to START (no idle gap); otherwise go to IDLE.
- `wr_data` is never read after the write edge, so the byte in flight is unaffected by later writes.
- Reset mid-frame: the frame is abandoned, the FIFO is flushed, and `uart_tx` returns high immediately (asynchronously).

## Timing
- Reset values: `uart_tx`=1, `full`=0, `empty`=1, `busy`=0, `overflow`=0, `level`=0. FSM=IDLE, pointers=0, bit counter=0.
- `uart_tx`, `busy`, `full`, `empty` and `level` are all registered outputs.
- Write at edge E0 (FIFO previously empty, FSM IDLE):
  - `empty` falls and `level`=1 after E0.
  - At E1 the FSM pops, and `uart_tx` falls and `busy` rises after E1.
  - Write-to-start-bit latency is 1 cycle.
- Frame length: 10·DIV cycles, or 11·DIV with parity.
- Back-to-back throughput: one byte per frame length, with no idle cycles between frames.
- `busy` falls on the edge that ends the last STOP bit when the FIFO is empty.

## Configuration
- `BF_UART_TX_PARITY_EN` defined: the PARITY state is compiled in and frames are 8E1 (11 bits).
- `BF_UART_TX_PARITY_EN` not defined: the PARITY state and its logic are absent and frames are 8N1 (10 bits).

## Test plan
All scenarios use default parameters, so DIV=434.
- Single byte: reset, then `wr_en` with 0x41 → `uart_tx` low 1 cycle after the write edge. Line then decodes start,1,0,0,0,0,0,1,0,stop, 434 cycles per bit. `busy` is high for exactly 4340 cycles.
- Back-to-back: write 0x55 then 0xAA on consecutive cycles → two frames with no high gap between stop and the next start. `level` reads 2→1→0 across the pops.
- Overflow: write 17 bytes 0x00..0x10 with the FSM stalled (line busy) → after the 17th write, `full`=1 and `overflow`=1. Byte 0x10 (the 17th) never appears on the line, so the line carries 0x00..0x0F in order.
- Full-with-pop: with the FIFO full, `wr_en` on the same edge as a STOP-end pop → write dropped, `overflow` set, `level`=FIFO_DEPTH-1.
- Reset mid-frame: assert `rst` during DATA bit 3 → `uart_tx`=1 immediately. After release, `empty`=1, `level`=0 and no residual frame appears.
- Parity build: with `BF_UART_TX_PARITY_EN`, send 0x07 → parity bit 1 and frame length 4774 cycles.
